// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch and data load/store.
// Optional stall counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT      = 2,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        if_flush,
    input  logic        hlt,
    output logic        if_valid,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_valid,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_if_stall,
    output logic [31:0] perf_d_stall
`endif
);

    localparam int unsigned CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [CNT_W-1:0]    WAIT_LAST  = CNT_W'(MEM_LAT - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q,  state_n;
    logic                own_d_q,  own_d_n;
    logic                cancel_q, cancel_n;
    logic [CNT_W-1:0]    cnt_q,    cnt_n;
    logic [STREAK_W-1:0] streak_q, streak_n;
    logic                mem_en_n, mem_wr_n;
    logic [15:0]         mem_addr_n, mem_wdata_n;

    logic if_elig;
    logic d_win;
    logic last_wait;

    assign if_elig   = if_req & ~if_flush & ~hlt;
    assign d_win     = d_req & ~(if_elig & (streak_q == STREAK_MAX));
    assign last_wait = (state_q == S_WAIT) && (cnt_q == WAIT_LAST);

    // Next-state, grant and memory command decode
    always_comb begin
        state_n     = state_q;
        own_d_n     = own_d_q;
        cancel_n    = cancel_q;
        cnt_n       = cnt_q;
        streak_n    = streak_q;
        mem_en_n    = 1'b0;
        mem_wr_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;

        case (state_q)
            S_IDLE: begin
                cancel_n = 1'b0;
                cnt_n    = '0;
                if (d_win) begin
                    state_n     = S_ISSUE;
                    own_d_n     = 1'b1;
                    mem_en_n    = 1'b1;
                    mem_wr_n    = d_wr;
                    mem_addr_n  = d_addr;
                    mem_wdata_n = d_wdata;
                    // The streak only measures how long a waiting fetch has been passed over
                    if (!if_req) begin
                        streak_n = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_n = streak_q + STREAK_W'(1);
                    end
                end else if (if_elig) begin
                    state_n    = S_ISSUE;
                    own_d_n    = 1'b0;
                    mem_en_n   = 1'b1;
                    mem_addr_n = if_addr;
                    streak_n   = '0;
                end else if (!if_req) begin
                    streak_n = '0;
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT;
                cnt_n   = '0;
            end
            S_WAIT: begin
                if (last_wait) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // A flushed fetch still occupies the memory but must not report data
        if (!own_d_q && (state_q != S_IDLE) && if_flush) begin
            cancel_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            own_d_q   <= 1'b0;
            cancel_q  <= 1'b0;
            cnt_q     <= '0;
            streak_q  <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_n;
            own_d_q   <= own_d_n;
            cancel_q  <= cancel_n;
            cnt_q     <= cnt_n;
            streak_q  <= streak_n;
            mem_en    <= mem_en_n;
            mem_wr    <= mem_wr_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
        end
    end

    // Completion pulses pass memory data straight through in the final wait cycle
    always_comb begin
        if_valid = last_wait & ~own_d_q & ~cancel_q & ~if_flush & ~rst;
        d_valid  = last_wait & own_d_q & ~rst;
        if_rdata = if_valid ? mem_rdata : 16'h0000;
        d_rdata  = d_valid  ? mem_rdata : 16'h0000;
    end

`ifdef MEM_ARB_PERF_CNT_EN
    // Saturating per-port stall counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_stall <= '0;
            perf_d_stall  <= '0;
        end else begin
            if (if_req && !if_valid && (perf_if_stall != 32'hFFFF_FFFF)) begin
                perf_if_stall <= perf_if_stall + 32'd1;
            end
            if (d_req && !d_valid && (perf_d_stall != 32'hFFFF_FFFF)) begin
                perf_d_stall <= perf_d_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-timeline reference model.
module tb_mem_port_arbiter;

    localparam int MEM_LAT      = 2;
    localparam int MAX_D_STREAK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, hlt, if_valid;
    logic [15:0] if_addr, if_rdata;
    logic        d_req, d_wr, d_valid;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall, perf_d_stall;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MEM_LAT      (MEM_LAT),
        .MAX_D_STREAK (MAX_D_STREAK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .hlt       (hlt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_if_stall (perf_if_stall),
        .perf_d_stall  (perf_d_stall)
`endif
    );

    // Memory environment: fixed read latency, junk on the bus when no read is returning
    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    logic [15:0] rd_pipe [MEM_LAT];
    int          cyc = 0;

    assign mem_rdata = rd_pipe[MEM_LAT-1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_en) begin
            rd_pipe[0] <= mem[mem_addr[7:0]];
            if (mem_wr) mem[mem_addr[7:0]] = mem_wdata;
        end else begin
            rd_pipe[0] <= 16'hDEAD ^ 16'(cyc);
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (tb cycle %0d)", tag, got, exp, tc);
        end
    endtask

    // Reference model: each access is a timeline anchored at its grant cycle g:
    // mem_en at g+1, completion at g+1+MEM_LAT, next grant possible after that.
    int          tc = 0;
    bit          m_busy, m_own_d, m_wr, m_cancel;
    int          m_g, m_streak;
    logic [15:0] m_addr, m_wdata;
    logic [31:0] m_pif, m_pd;

    // Requester and stimulus knobs
    bit i_pend, d_pend, force_rst, force_flush, rec_on;
    int p_ireq, p_dreq, p_flush, p_hlt, p_rst;
    bit seq[$];

    task automatic run_cycle();
        bit e_mem_en, e_mem_wr, last, e_iv, e_dv, elig;
        @(posedge clk);
        #1;
        rst         = force_rst || ($urandom_range(0, 999) < p_rst);
        force_rst   = 1'b0;
        hlt         = ($urandom_range(0, 99) < p_hlt);
        if_flush    = force_flush || ($urandom_range(0, 99) < p_flush);
        force_flush = 1'b0;
        if (if_flush) i_pend = 1'b0;
        if (!i_pend && ($urandom_range(0, 99) < p_ireq)) begin
            i_pend  = 1'b1;
            if_addr = 16'($urandom);
        end
        if_req = i_pend;
        if (!d_pend && ($urandom_range(0, 99) < p_dreq)) begin
            d_pend  = 1'b1;
            d_wr    = 1'($urandom_range(0, 1));
            d_addr  = 16'($urandom);
            d_wdata = 16'($urandom);
        end
        d_req = d_pend;

        @(negedge clk);
        if (m_busy && (tc > m_g + 1 + MEM_LAT)) m_busy = 1'b0;
        e_mem_en = m_busy && (tc == m_g + 1);
        e_mem_wr = e_mem_en && m_own_d && m_wr;
        last     = m_busy && (tc == m_g + 1 + MEM_LAT);
        e_iv     = last && !m_own_d && !m_cancel && !if_flush && !rst;
        e_dv     = last && m_own_d && !rst;

        check_eq("mem_en", 32'(mem_en), 32'(e_mem_en));
        check_eq("mem_wr", 32'(mem_wr), 32'(e_mem_wr));
        if (e_mem_en) check_eq("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (e_mem_wr) check_eq("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        check_eq("if_valid", 32'(if_valid), 32'(e_iv));
        check_eq("d_valid", 32'(d_valid), 32'(e_dv));
        check_eq("if_rdata", 32'(if_rdata), e_iv ? 32'(ref_mem[m_addr[7:0]]) : 32'h0);
        if (!(e_dv && m_wr))
            check_eq("d_rdata", 32'(d_rdata), e_dv ? 32'(ref_mem[m_addr[7:0]]) : 32'h0);
`ifdef MEM_ARB_PERF_CNT_EN
        check_eq("perf_if_stall", perf_if_stall, m_pif);
        check_eq("perf_d_stall", perf_d_stall, m_pd);
        if (rst) begin
            m_pif = '0;
            m_pd  = '0;
        end else begin
            if (if_req && !e_iv && (m_pif != 32'hFFFF_FFFF)) m_pif = m_pif + 32'd1;
            if (d_req && !e_dv && (m_pd != 32'hFFFF_FFFF)) m_pd = m_pd + 32'd1;
        end
`endif
        if (rec_on) begin
            if (if_valid) seq.push_back(1'b0);
            if (d_valid) seq.push_back(1'b1);
        end

        if (e_mem_wr) ref_mem[m_addr[7:0]] = m_wdata;
        if (e_iv) i_pend = 1'b0;
        if (e_dv) d_pend = 1'b0;
        if (m_busy && !m_own_d && (tc > m_g) && if_flush) m_cancel = 1'b1;

        elig = if_req && !if_flush && !hlt;
        if (rst) begin
            m_busy   = 1'b0;
            m_cancel = 1'b0;
            m_streak = 0;
        end else if (!m_busy) begin
            if (d_req && !(elig && (m_streak == MAX_D_STREAK))) begin
                m_busy = 1'b1; m_g = tc; m_own_d = 1'b1; m_cancel = 1'b0;
                m_addr = d_addr; m_wr = d_wr; m_wdata = d_wdata;
                if (!if_req) m_streak = 0;
                else if (m_streak < MAX_D_STREAK) m_streak = m_streak + 1;
            end else if (elig) begin
                m_busy = 1'b1; m_g = tc; m_own_d = 1'b0; m_cancel = 1'b0;
                m_addr = if_addr; m_wr = 1'b0;
                m_streak = 0;
            end else if (!if_req) begin
                m_streak = 0;
            end
        end
        tc++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    logic [5:0] exp_seq;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 16'h0101) ^ 16'h3C5A;
            ref_mem[i] = 16'(i * 16'h0101) ^ 16'h3C5A;
        end
        mem[8'h10]     = 16'hA123;
        ref_mem[8'h10] = 16'hA123;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0; hlt = 1'b0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        m_busy = 1'b0; m_own_d = 1'b0; m_wr = 1'b0; m_cancel = 1'b0;
        m_g = 0; m_streak = 0; m_addr = '0; m_wdata = '0; m_pif = '0; m_pd = '0;
        i_pend = 1'b0; d_pend = 1'b0; force_rst = 1'b0; force_flush = 1'b0; rec_on = 1'b0;
        p_ireq = 0; p_dreq = 0; p_flush = 0; p_hlt = 0; p_rst = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_en", 32'(mem_en), 32'h0);
        check_eq("rst_mem_wr", 32'(mem_wr), 32'h0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check_eq("rst_if_valid", 32'(if_valid), 32'h0);
        check_eq("rst_d_valid", 32'(d_valid), 32'h0);

        // Single fetch of 0x0010
        i_pend = 1'b1; if_addr = 16'h0010;
        run_n(6);
        // Store 0xBEEF to 0x0040, then load it back
        d_pend = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
        run_n(5);
        d_pend = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
        run_n(5);
        // Fetch and load requested together
        i_pend = 1'b1; if_addr = 16'h0010;
        d_pend = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
        run_n(10);

        // Starvation guard with both ports continuously requesting
        force_rst = 1'b1;
        run_cycle();
        p_ireq = 100; p_dreq = 100; rec_on = 1'b1;
        seq.delete();
        run_n(30);
        rec_on = 1'b0; p_ireq = 0; p_dreq = 0;
        exp_seq = 6'b101111;
        check_eq("starve_len", 32'(seq.size() >= 6), 32'h1);
        for (int i = 0; i < 6; i++)
            if (i < seq.size()) check_eq("starve_seq", 32'(seq[i]), 32'(exp_seq[i]));

        // Fetch flushed while waiting, then a new fetch
        force_rst = 1'b1; i_pend = 1'b0; d_pend = 1'b0;
        run_cycle();
        i_pend = 1'b1; if_addr = 16'h0123;
        run_n(2);
        force_flush = 1'b1;
        run_cycle();
        i_pend = 1'b1; if_addr = 16'h0456;
        run_n(8);

        // Reset during a load's wait phase
        d_pend = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
        run_n(2);
        force_rst = 1'b1;
        run_n(10);

        // Long randomized mix
        p_ireq = 40; p_dreq = 40; p_flush = 8; p_hlt = 10; p_rst = 5;
        run_n(3000);
        p_ireq = 0; p_dreq = 0; p_flush = 0; p_hlt = 0; p_rst = 0;
        run_n(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
